// File: rtl/reg_file_if.sv
// Register-file access bus: two combinational read ports and one write port.
// The master drives indices and write data; the slave (reg_file) returns read data.
interface reg_file_if #(
    parameter int unsigned ADDRESS_WIDTH = 5,
    parameter int unsigned DATA_WIDTH    = 32
);
    logic [ADDRESS_WIDTH-1:0] AD1;
    logic [ADDRESS_WIDTH-1:0] AD2;
    logic [ADDRESS_WIDTH-1:0] AD3;
    logic                     WE3;
    logic [DATA_WIDTH-1:0]    WD3;
    logic [DATA_WIDTH-1:0]    RD1;
    logic [DATA_WIDTH-1:0]    RD2;

    modport master (
        output AD1, AD2, AD3, WE3, WD3,
        input  RD1, RD2
    );

    modport slave (
        input  AD1, AD2, AD3, WE3, WD3,
        output RD1, RD2
    );
endinterface

// File: rtl/reg_file.sv
// Architectural integer register file (x0 hardwired to zero) with a registered copy of x10.
// Optional macro REGFILE_BYPASS_EN enables write-first forwarding from WD3 to the read ports.
module reg_file #(
    parameter int unsigned ADDRESS_WIDTH = 5,
    parameter int unsigned DATA_WIDTH    = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    reg_file_if.slave             bus,
    output logic [DATA_WIDTH-1:0] a0
);
    localparam int unsigned DEPTH = 2 ** ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] A0_IDX = ADDRESS_WIDTH'(10);

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] rd1;
    logic [DATA_WIDTH-1:0] rd2;

    // x0 is never written, so a write to index 0 is simply dropped here.
    assign wr_en = bus.WE3 && (bus.AD3 != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[bus.AD3] <= bus.WD3;
        end
    end

    // a0 must show the post-edge value of x10, so take WD3 directly when this edge writes x10.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a0 <= '0;
        end else if (wr_en && (bus.AD3 == A0_IDX)) begin
            a0 <= bus.WD3;
        end else begin
            a0 <= regs[A0_IDX];
        end
    end

    always_comb begin
        rd1 = '0;
        if (bus.AD1 != '0) begin
            rd1 = regs[bus.AD1];
        end
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (bus.AD1 == bus.AD3)) begin
            rd1 = bus.WD3;
        end
`endif
    end

    always_comb begin
        rd2 = '0;
        if (bus.AD2 != '0) begin
            rd2 = regs[bus.AD2];
        end
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (bus.AD2 == bus.AD3)) begin
            rd2 = bus.WD3;
        end
`endif
    end

    assign bus.RD1 = rd1;
    assign bus.RD2 = rd2;
endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file; expectations follow REGFILE_BYPASS_EN when defined.
module tb_reg_file;
    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] a0;
    int unsigned   n_checks;
    int unsigned   n_fail;
    logic [DW-1:0] hz_exp;

    reg_file_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    reg_file #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .a0    (a0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] idx, input logic [DW-1:0] data);
        bus.WE3 = 1'b1;
        bus.AD3 = idx;
        bus.WD3 = data;
        tick();
        bus.WE3 = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus.AD1  = 5'd5;
        bus.AD2  = 5'd10;
        bus.AD3  = '0;
        bus.WE3  = 1'b0;
        bus.WD3  = '0;
        #2;
        check("reset_rd1", bus.RD1, 32'h0);
        check("reset_rd2", bus.RD2, 32'h0);
        check("reset_a0", a0, 32'h0);
        tick();
        rst_n = 1'b1;

        // Fill x5 and x10, then reset asynchronously between edges
        wr(5'd5, 32'hDEADBEEF);
        wr(5'd10, 32'hDEADBEEF);
        #1;
        check("pre_rst_rd1", bus.RD1, 32'hDEADBEEF);
        check("pre_rst_rd2", bus.RD2, 32'hDEADBEEF);
        check("pre_rst_a0", a0, 32'hDEADBEEF);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_rd1", bus.RD1, 32'h0);
        check("async_rst_rd2", bus.RD2, 32'h0);
        check("async_rst_a0", a0, 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            bus.AD1 = AW'(i);
            #1;
            check("post_rst_all", bus.RD1, 32'h0);
        end

        // x0 immutability, including while the write to 0 is pending
        tick();
        bus.WE3 = 1'b1;
        bus.AD3 = 5'd0;
        bus.WD3 = 32'hFFFFFFFF;
        bus.AD1 = 5'd0;
        #1;
        check("x0_pending", bus.RD1, 32'h0);
        tick();
        bus.WE3 = 1'b0;
        #1;
        check("x0_after", bus.RD1, 32'h0);

        // Write and read on both ports
        wr(5'd3, 32'h00000007);
        wr(5'd4, 32'h80000000);
        bus.AD1 = 5'd3;
        bus.AD2 = 5'd4;
        #1;
        check("rd1_x3", bus.RD1, 32'h00000007);
        check("rd2_x4", bus.RD2, 32'h80000000);
        bus.AD1 = 5'd4;
        #1;
        check("both_x4_rd1", bus.RD1, 32'h80000000);
        check("both_x4_rd2", bus.RD2, 32'h80000000);

        // Same-cycle read/write hazard on x7
        wr(5'd7, 32'h00000011);
        bus.WE3 = 1'b1;
        bus.AD3 = 5'd7;
        bus.WD3 = 32'h00000022;
        bus.AD1 = 5'd7;
        bus.AD2 = 5'd7;
`ifdef REGFILE_BYPASS_EN
        hz_exp = 32'h00000022;
`else
        hz_exp = 32'h00000011;
`endif
        #1;
        check("hazard_rd1", bus.RD1, hz_exp);
        check("hazard_rd2", bus.RD2, hz_exp);
        tick();
        bus.WE3 = 1'b0;
        #1;
        check("hazard_after_rd1", bus.RD1, 32'h00000022);
        check("hazard_after_rd2", bus.RD2, 32'h00000022);

        // a0 tracks x10 on the writing edge and ignores other writes
        wr(5'd10, 32'h0000002A);
        check("a0_write", a0, 32'h0000002A);
        wr(5'd11, 32'h00000099);
        check("a0_hold", a0, 32'h0000002A);
        bus.AD1 = 5'd11;
        bus.AD2 = 5'd10;
        #1;
        check("rd1_x11", bus.RD1, 32'h00000099);
        check("rd2_x10", bus.RD2, 32'h0000002A);

        // WE3 low: no store and no forwarding
        bus.WE3 = 1'b0;
        bus.AD3 = 5'd9;
        bus.WD3 = 32'h00001234;
        bus.AD1 = 5'd9;
        #1;
        check("we_low_pending", bus.RD1, 32'h0);
        tick();
        check("we_low_after", bus.RD1, 32'h0);

        // A write on an edge while rst_n is low is lost
        rst_n   = 1'b0;
        bus.WE3 = 1'b1;
        bus.AD3 = 5'd12;
        bus.WD3 = 32'h00000005;
        tick();
        bus.WE3 = 1'b0;
        rst_n   = 1'b1;
        bus.AD1 = 5'd12;
        bus.AD2 = 5'd7;
        #1;
        check("wr_in_rst_x12", bus.RD1, 32'h0);
        check("wr_in_rst_x7", bus.RD2, 32'h0);
        check("wr_in_rst_a0", a0, 32'h0);

        // First edge after release writes
        wr(5'd12, 32'hA5A5A5A5);
        check("first_edge_wr", bus.RD1, 32'hA5A5A5A5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
